platform_field: RTL and testbench
=================================

PLATFORM_FIELD -- requirements
Module: platform_field

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_PLAT, 8, platform table entries.
- PLAT_W, 60, platform width in px.
- PLAT_H, 10, platform height in px.
- DOODLE_W, 40, doodle width in px.
- SCROLL_LINE, 300, doodle_y threshold that triggers scroll.
- MAX_SCROLL, 15, max scroll px per frame.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock.
- rst, in, 1, asynchronous, active-low reset.
- frame_start, in, 1, one-cycle pulse at start of vertical blanking.
- beam_x, in, 11, current pixel column, 0..1279.
- beam_y, in, 10, current pixel row, 0..719.
- doodle_x, in, 11, doodle left edge.
- doodle_y, in, 10, doodle feet row.
- doodle_falling, in, 1, doodle vertical velocity downward.
- collision, out, 1, doodle landed on a platform this frame.
- landed_y, out, 10, top row of the platform landed on.
- pixel_on, out, 1, beam pixel lies on a platform.
- color, out, [2:0][3:0], RGB for the pixel; index 0 = R.
- score, out, 16, cumulative scrolled px.

Function
REQ-003 Table entries SHALL each hold px (11 b) and py (10 b).
REQ-004 A 16-bit Fibonacci LFSR SHALL use taps 16,14,13,11, seed 16'hACE1, and advance every clk.
REQ-005 The FSM SHALL have states IDLE, SCROLL, COLLIDE, using index counter i (0..N_PLAT-1).
REQ-006 IDLE SHALL go to SCROLL on frame_start, with i=0 and the scroll amount s latched the same cycle.
REQ-007 s SHALL be min(SCROLL_LINE-doodle_y, MAX_SCROLL) if doodle_y < SCROLL_LINE, else 0.
REQ-008 SCROLL SHALL process one entry per cycle: py_new = py+s; if py_new >= 720, respawn with py = py_new-720 and px = r if r < 1220, else r-1024, where r = lfsr[10:0].
REQ-009 After entry N_PLAT-1, SCROLL SHALL go to COLLIDE with i=0, and score SHALL add s, saturating at 16'hFFFF.
REQ-010 COLLIDE SHALL test one entry per cycle and match when all of the following hold:
- doodle_falling;
- doodle_x+DOODLE_W > px;
- doodle_x < px+PLAT_W;
- py <= doodle_y < py+PLAT_H.
REQ-011 The lowest-index match SHALL win.
REQ-012 After entry N_PLAT-1, collision and landed_y SHALL update together: collision = any match; landed_y = winning py, or 0 if none. The FSM then returns to IDLE, giving 16 cycles of latency from frame_start.
REQ-013 collision and landed_y SHALL hold their values until the next COLLIDE completion.
REQ-014 frame_start SHALL be ignored outside IDLE.
REQ-015 doodle inputs SHALL be sampled during COLLIDE each cycle; the driver holds them stable through the frame.
REQ-016 pixel_on SHALL be registered, one clk after beam_x/beam_y, and be 1 iff some entry has px <= beam_x < px+PLAT_W and py <= beam_y < py+PLAT_H, evaluated on the current table contents.
REQ-017 color SHALL be {4'h2,4'hB,4'h2} when pixel_on=1, else all zero, aligned with pixel_on.
REQ-018 All comparisons SHALL be unsigned, with sums widened by 1 bit so there is no wrap (e.g. px+PLAT_W up to 1279+60).

Reset
REQ-019 While rst=0 the following SHALL hold:
- state = IDLE, i = 0, lfsr = 16'hACE1;
- collision = 0, landed_y = 0, pixel_on = 0, color = 0, score = 0.
REQ-020 Reset table SHALL be entry k: py = 700-90*k, px = (40+157*k) mod 1220, giving k=0: (40,700) and k=1: (197,610).
REQ-021 Reset assertion mid-SCROLL/COLLIDE SHALL abort immediately to the reset values; no partial update survives.

Verification
REQ-022 Release reset, doodle_x=30, doodle_y=705, falling=1, pulse frame_start -> 16 cycles later collision=1, landed_y=700, score=0.
REQ-023 Same as REQ-022 with falling=0 -> collision=0, landed_y=0.
REQ-024 doodle_y=250 (s=15), frame_start -> entry 0 py=715, score=15; a second frame_start -> entry 0 respawns with py=10 and px in 0..1219, score=30.
REQ-025 Beam sweep of row 705 after reset -> pixel_on=1 one cycle after beam_x=40..99, 0 elsewhere; color=2,B,2 only when pixel_on=1.
REQ-026 Second frame_start 5 cycles into processing -> ignored, result still appears at cycle 16; rst=0 pulse at cycle 10 -> outputs 0 and table back at its reset layout.

Source files
------------

// File: rtl/platform_field.sv
// Platform table for a vertical scroller: per-frame scroll/respawn,
// doodle landing detection, and a registered platform pixel mask.
module platform_field #(
  parameter int N_PLAT      = 8,
  parameter int PLAT_W      = 60,
  parameter int PLAT_H      = 10,
  parameter int DOODLE_W    = 40,
  parameter int SCROLL_LINE = 300,
  parameter int MAX_SCROLL  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic [10:0]     beam_x,
  input  logic [9:0]      beam_y,
  input  logic [10:0]     doodle_x,
  input  logic [9:0]      doodle_y,
  input  logic            doodle_falling,
  output logic            collision,
  output logic [9:0]      landed_y,
  output logic            pixel_on,
  output logic [2:0][3:0] color,
  output logic [15:0]     score
);

  localparam int IW = (N_PLAT > 1) ? $clog2(N_PLAT) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_PLAT - 1);
  localparam logic [11:0] PW12 = 12'(PLAT_W);
  localparam logic [11:0] DW12 = 12'(DOODLE_W);
  localparam logic [10:0] PH11 = 11'(PLAT_H);
  localparam logic [9:0]  SL10 = 10'(SCROLL_LINE);
  localparam logic [9:0]  MS10 = 10'(MAX_SCROLL);

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    COLLIDE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [9:0]    s_q, s_calc;
  logic [15:0]   lfsr_q;
  logic [15:0]   score_q;
  logic [16:0]   score_sum;
  logic          hit_q, hit_d, prev_hit, m;
  logic [9:0]    hy_q, hy_d;
  logic          collision_q;
  logic [9:0]    landed_q;
  logic          pix_q, pix_d;
  logic [10:0]   px_q [N_PLAT];
  logic [9:0]    py_q [N_PLAT];
  logic [10:0]   cur_px, px_new, r;
  logic [9:0]    cur_py, py_new, diff;
  logic [10:0]   py_sum;
  logic          scroll_last, collide_last;

  assign cur_px = px_q[i_q];
  assign cur_py = py_q[i_q];
  assign r      = lfsr_q[10:0];

  assign scroll_last  = (state_q == SCROLL) && (i_q == LAST);
  assign collide_last = (state_q == COLLIDE) && (i_q == LAST);

  // Scroll amount derived from how far the doodle is above the line
  always_comb begin
    diff   = SL10 - doodle_y;
    s_calc = '0;
    if (doodle_y < SL10) s_calc = (diff > MS10) ? MS10 : diff;
  end

  // Scrolled position of the current entry and its respawn column
  always_comb begin
    py_sum = {1'b0, cur_py} + {1'b0, s_q};
    py_new = py_sum[9:0];
    px_new = cur_px;
    if (py_sum >= 11'd720) begin
      py_new = 10'(py_sum - 11'd720);
      px_new = (r < 11'd1220) ? r : (r - 11'd1024);
    end
  end

  // Landing test for the current entry; lowest index keeps priority
  always_comb begin
    m = doodle_falling
      && (({1'b0, doodle_x} + DW12) > {1'b0, cur_px})
      && ({1'b0, doodle_x} < ({1'b0, cur_px} + PW12))
      && (cur_py <= doodle_y)
      && ({1'b0, doodle_y} < ({1'b0, cur_py} + PH11));
    prev_hit = (i_q == '0) ? 1'b0 : hit_q;
    hit_d    = prev_hit | m;
    hy_d     = prev_hit ? hy_q : (m ? cur_py : '0);
  end

  // Beam hit test against every table entry
  always_comb begin
    pix_d = 1'b0;
    for (int k = 0; k < N_PLAT; k++) begin
      if ((px_q[k] <= beam_x)
          && ({1'b0, beam_x} < ({1'b0, px_q[k]} + PW12))
          && (py_q[k] <= beam_y)
          && ({1'b0, beam_y} < ({1'b0, py_q[k]} + PH11)))
        pix_d = 1'b1;
    end
  end

  assign score_sum = {1'b0, score_q} + {7'b0, s_q};

  // Next-state and entry index sequencing
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SCROLL;
          i_d     = '0;
        end
      end
      SCROLL: begin
        if (i_q == LAST) begin
          state_d = COLLIDE;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      COLLIDE: begin
        if (i_q == LAST) begin
          state_d = IDLE;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        i_d     = '0;
      end
    endcase
  end

  // Control, LFSR, score and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      s_q         <= '0;
      lfsr_q      <= 16'hACE1;
      score_q     <= '0;
      hit_q       <= 1'b0;
      hy_q        <= '0;
      collision_q <= 1'b0;
      landed_q    <= '0;
      pix_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      lfsr_q  <= {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      pix_q   <= pix_d;
      if (state_q == IDLE && frame_start) s_q <= s_calc;
      if (scroll_last)
        score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      if (state_q == COLLIDE) begin
        hit_q <= hit_d;
        hy_q  <= hy_d;
      end
      if (collide_last) begin
        collision_q <= hit_d;
        landed_q    <= hy_d;
      end
    end
  end

  // Platform table: staggered reset layout, one entry scrolled per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_PLAT; k++) begin
        py_q[k] <= 10'(700 - 90 * k);
        px_q[k] <= 11'((40 + 157 * k) % 1220);
      end
    end else if (state_q == SCROLL) begin
      for (int k = 0; k < N_PLAT; k++) begin
        if (i_q == IW'(k)) begin
          py_q[k] <= py_new;
          px_q[k] <= px_new;
        end
      end
    end
  end

  assign collision = collision_q;
  assign landed_y  = landed_q;
  assign score     = score_q;
  assign pixel_on  = pix_q;
  assign color     = pix_q ? {4'h2, 4'hB, 4'h2} : '0;

endmodule

// File: tb/tb_platform_field.sv
// Scoreboard bench for platform_field: frame results and pixel
// probes are predicted by a table model and checked by a monitor.
module tb_platform_field;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            frame_start = 1'b0;
  logic [10:0]     beam_x = '0;
  logic [9:0]      beam_y = '0;
  logic [10:0]     doodle_x = '0;
  logic [9:0]      doodle_y = '0;
  logic            doodle_falling = 1'b0;
  logic            collision;
  logic [9:0]      landed_y;
  logic            pixel_on;
  logic [2:0][3:0] color;
  logic [15:0]     score;

  platform_field dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .beam_x         (beam_x),
    .beam_y         (beam_y),
    .doodle_x       (doodle_x),
    .doodle_y       (doodle_y),
    .doodle_falling (doodle_falling),
    .collision      (collision),
    .landed_y       (landed_y),
    .pixel_on       (pixel_on),
    .color          (color),
    .score          (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int col;
    int ly;
    int sc;
  } fexp_t;

  typedef struct {
    int due;
    int pix;
  } pexp_t;

  fexp_t fq[$];
  pexp_t pq[$];
  fexp_t fe;
  pexp_t pe;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    mpx [8];
  int    mpy [8];
  int    msc;

  // cycles since reset release; the LFSR is a pure function of it
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int lfsr_at(int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int j = 0; j < n; j++)
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return int'(v);
  endfunction

  function automatic int model_pix(int x, int y);
    for (int k = 0; k < 8; k++)
      if (mpx[k] <= x && x < mpx[k] + 60 &&
          mpy[k] <= y && y < mpy[k] + 10)
        return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      mpy[k] = 700 - 90 * k;
      mpx[k] = (40 + 157 * k) % 1220;
    end
    msc = 0;
  endtask

  // monitor: compares whatever the DUT presents when it falls due
  always @(negedge clk) begin
    if (fq.size() > 0 && fq[0].due <= cyc) begin
      fe = fq.pop_front();
      chk("collision", int'(collision), fe.col);
      chk("landed_y", int'(landed_y), fe.ly);
      chk("score", int'(score), fe.sc);
    end
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      pe = pq.pop_front();
      chk("pixel_on", int'(pixel_on), pe.pix);
      chk("color", int'(color), pe.pix != 0 ? 'h2B2 : 0);
    end
  end

  task automatic probe(int x, int y);
    pexp_t p;
    @(negedge clk);
    beam_x = 11'(x);
    beam_y = 10'(y);
    p.due = cyc + 1;
    p.pix = model_pix(x, y);
    pq.push_back(p);
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_frame(int dx, int dy, int fall, bit dup);
    fexp_t e;
    int s, c0, p, rr, col, ly;
    @(negedge clk);
    doodle_x = 11'(dx);
    doodle_y = 10'(dy);
    doodle_falling = fall[0];
    frame_start = 1'b1;
    c0 = cyc;
    s = 0;
    if (dy < 300) s = (300 - dy > 15) ? 15 : 300 - dy;
    for (int k = 0; k < 8; k++) begin
      rr = lfsr_at(c0 + 1 + k) & 'h7FF;
      p = mpy[k] + s;
      if (p >= 720) begin
        mpy[k] = p - 720;
        mpx[k] = (rr < 1220) ? rr : rr - 1024;
      end else begin
        mpy[k] = p;
      end
    end
    msc = (msc + s > 65535) ? 65535 : msc + s;
    col = 0;
    ly = 0;
    for (int k = 0; k < 8; k++)
      if (col == 0 && fall != 0 && dx + 40 > mpx[k] &&
          dx < mpx[k] + 60 && mpy[k] <= dy && dy < mpy[k] + 10) begin
        col = 1;
        ly = mpy[k];
      end
    e.due = c0 + 17;
    e.col = col;
    e.ly = ly;
    e.sc = msc;
    fq.push_back(e);
    @(negedge clk);
    frame_start = 1'b0;
    if (dup) begin
      repeat (4) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
    while (cyc < c0 + 17) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_collision", int'(collision), 0);
    chk("rst_landed_y", int'(landed_y), 0);
    chk("rst_pixel_on", int'(pixel_on), 0);
    chk("rst_color", int'(color), 0);
    chk("rst_score", int'(score), 0);
  endtask

  task automatic rand_probes(int n);
    int e, x, y;
    for (int j = 0; j < n; j++) begin
      if (j % 2 == 0) begin
        e = $urandom_range(0, 7);
        x = mpx[e] + $urandom_range(0, 70) - 5;
        y = mpy[e] + $urandom_range(0, 13) - 2;
      end else begin
        x = $urandom_range(0, 1279);
        y = $urandom_range(0, 719);
      end
      if (x < 0) x = 0;
      if (x > 1279) x = 1279;
      if (y < 0) y = 0;
      if (y > 719) y = 719;
      probe(x, y);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, dx, dy, fl;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    drain();

    for (int x = 0; x < 1280; x++) probe(x, 705);
    probe(50, 700);
    probe(50, 710);
    drain();

    do_frame(30, 705, 1, 0);
    do_frame(30, 705, 0, 0);
    do_frame(30, 250, 1, 0);
    probe(50, 715);
    probe(99, 719);
    probe(100, 716);
    do_frame(30, 250, 1, 0);
    rand_probes(20);
    drain();

    do_frame(mpx[1], mpy[1] + 3, 1, 1);
    drain();

    @(negedge clk);
    doodle_x = 11'd30;
    doodle_y = 10'd705;
    doodle_falling = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (8) @(negedge clk);
    fq.delete();
    pq.delete();
    rst = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int x = 0; x < 200; x++) probe(x, 705);
    drain();
    do_frame(30, 705, 1, 0);

    for (int j = 0; j < 40; j++) begin
      e = $urandom_range(0, 7);
      dx = mpx[e] + $urandom_range(0, 110) - 45;
      if (dx < 0) dx = 0;
      if (dx > 1279) dx = 1279;
      if ($urandom_range(0, 2) == 0) dy = $urandom_range(0, 719);
      else dy = mpy[e] + $urandom_range(0, 11) - 1;
      if (dy < 0) dy = 0;
      if (dy > 719) dy = 719;
      fl = ($urandom_range(0, 3) != 0) ? 1 : 0;
      do_frame(dx, dy, fl, j % 7 == 3);
      rand_probes(6);
    end
    repeat (4) @(negedge clk);
    if (fq.size() != 0 || pq.size() != 0) begin
      errors++;
      $display("FAIL pending got %0d expected 0",
               fq.size() + pq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
